window_gen_array: RTL and testbench

// - Streaming sliding-window generator for Tn input channels; successor to the fixed-mode line-buffer array.
// - Accepts raster-order feature pixels, one pixel per channel per beat, from the feature-buffer read path.
// - Emits a full K x K window per channel to the compute array.
// - Adds runtime kernel size, runtime stride, valid/ready backpressure and frame start/done control.

---
 rtl/window_gen_pkg.sv | 43 ++++
 rtl/window_gen_array_line_fifo.sv | 50 +++++
 rtl/window_gen_array.sv | 222 ++++++++++++++++++++++
 tb/tb_window_gen_array.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_gen_pkg.sv
// ---------------------------------------------------------------------------
// window_gen_pkg
// Shared definitions for the streaming sliding-window generator:
//   - state_t         : frame-control FSM states
//   - MAX_FEAT        : largest feature-map edge, also the line RAM depth
//   - kernel/stride legal limits and the clamp helpers that enforce them
//   - idx()           : flat tap index of (channel, row, col) in out_window
// No ports; imported by window_gen_array and line_fifo.
// ---------------------------------------------------------------------------
package window_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int MAX_FEAT   = 256;
  localparam int KERNEL_MIN = 1;
  localparam int STRIDE_MIN = 1;
  localparam int STRIDE_MAX = 3;

  // Flat tap position of channel i, window row r, window column c.
  function automatic int idx(input int i, input int r, input int c, input int kmax);
    return (i * kmax + r) * kmax + c;
  endfunction

  // Out-of-range kernel sizes fall back to the smallest legal kernel.
  function automatic logic [2:0] clamp_kernel(input logic [2:0] k, input int kmax);
    if (int'(k) < KERNEL_MIN || int'(k) > kmax)
      return 3'(KERNEL_MIN);
    return k;
  endfunction

  // Out-of-range strides fall back to the smallest legal stride.
  function automatic logic [1:0] clamp_stride(input logic [1:0] s);
    if (int'(s) < STRIDE_MIN || int'(s) > STRIDE_MAX)
      return 2'(STRIDE_MIN);
    return s;
  endfunction

endpackage

// File: rtl/window_gen_array_line_fifo.sv
// ---------------------------------------------------------------------------
// line_fifo
// One-channel delay line of runtime length W = last_idx + 1 beats.
// A circular RAM is read and written at the same pointer: the word read on
// a beat is the pixel written exactly W beats earlier, i.e. the pixel one
// raster line above. RAM contents are not reset.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (pointer only)
//   clear      : restart the pointer at a new frame
//   en         : shift one pixel in / out
//   last_idx   : W-1, the pointer wrap value
//   din, dout  : pixel entering / pixel delayed by one line
// ---------------------------------------------------------------------------
module line_fifo
  import window_gen_pkg::*;
#(
  parameter int FW    = 8,
  parameter int DEPTH = MAX_FEAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       en,
  input  logic [$clog2(DEPTH)-1:0]   last_idx,
  input  logic [FW-1:0]              din,
  output logic [FW-1:0]              dout
);

  localparam int AW = $clog2(DEPTH);

  logic [FW-1:0] ram [DEPTH];
  logic [AW-1:0] ptr;

  // Shared read/write pointer, wrapping at the runtime line end.
  always_ff @(posedge clk) begin
    if (rst || clear)
      ptr <= '0;
    else if (en)
      ptr <= (ptr == last_idx) ? '0 : ptr + 1'b1;
  end

  // Old word is read combinationally before being overwritten on the edge.
  always_ff @(posedge clk) begin
    if (en)
      ram[ptr] <= din;
  end

  assign dout = ram[ptr];

endmodule

// File: rtl/window_gen_array.sv
// ---------------------------------------------------------------------------
// window_gen_array
// Streaming K x K sliding-window generator for Tn parallel channels with
// runtime kernel size k, stride s and square feature edge W.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : latch cfg_* and begin a frame (ignored while busy)
//   cfg_kernel_size    : k, 1..KERNEL_SIZE (illegal -> 1)
//   cfg_stride         : s, 1..3 (illegal -> 1)
//   cfg_feature_size   : W-1 = H-1
//   in_valid/in_ready  : raster-order pixel beat, all channels in parallel
//   in_data            : channel i at [i*FW +: FW]
//   out_valid/out_ready: window handshake
//   out_window         : ch i, row r, col c at [((i*K+r)*K+c)*FW +: FW]
//   busy               : frame in RUN or DRAIN
//   done               : one-cycle pulse when the frame is finished
// ---------------------------------------------------------------------------
module window_gen_array
  import window_gen_pkg::*;
#(
  parameter int Tn            = 2,
  parameter int FEATURE_WIDTH = 8,
  parameter int KERNEL_SIZE   = 3
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               start,
  input  logic [2:0]                                         cfg_kernel_size,
  input  logic [1:0]                                         cfg_stride,
  input  logic [7:0]                                         cfg_feature_size,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [Tn*FEATURE_WIDTH-1:0]                        in_data,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [Tn*KERNEL_SIZE*KERNEL_SIZE*FEATURE_WIDTH-1:0] out_window,
  output logic                                               busy,
  output logic                                               done
);

  localparam int FW = FEATURE_WIDTH;
  localparam int K  = KERNEL_SIZE;
  localparam int NL = (K > 1) ? K - 1 : 1;
  localparam int WW = Tn * K * K * FW;

  state_t        state, state_nxt;
  logic [2:0]    k_cfg;
  logic [1:0]    s_cfg;
  logic [7:0]    last_idx;
  logic [7:0]    col, row;
  logic [1:0]    col_ph, row_ph;
  logic [7:0]    km1;
  logic [1:0]    s_last;
  logic          start_ok, accept, last_pixel, col_hit, row_hit, emit;

  logic [FW-1:0] line_out [Tn][NL];
  logic [FW-1:0] col_in   [Tn][K];
  logic [FW-1:0] win      [Tn][K][K];
  logic [FW-1:0] win_nxt  [Tn][K][K];
  logic [WW-1:0] win_masked;

  assign start_ok   = start && (state == ST_IDLE);
  assign accept     = in_valid && in_ready;
  assign last_pixel = (row == last_idx) && (col == last_idx);
  assign km1        = {5'd0, k_cfg} - 8'd1;
  assign s_last     = s_cfg - 2'd1;

  // The phase counters run modulo s once the kernel fits, so the stride
  // test needs no divider: phase 0 marks a window origin on that axis.
  assign col_hit = (col >= km1) && (col_ph == 2'd0);
  assign row_hit = (row >= km1) && (row_ph == 2'd0);
  assign emit    = accept && col_hit && row_hit;

  // State register and frame configuration, latched only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      k_cfg    <= 3'd1;
      s_cfg    <= 2'd1;
      last_idx <= 8'd0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        k_cfg    <= clamp_kernel(cfg_kernel_size, K);
        s_cfg    <= clamp_stride(cfg_stride);
        last_idx <= cfg_feature_size;
      end
    end
  end

  // Next state and control outputs. DRAIN waits for the final window to be
  // taken; a pending window cannot exist unless out_valid is high.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start)
          state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy     = 1'b1;
        in_ready = !out_valid || out_ready;
        if (accept && last_pixel)
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!out_valid || out_ready)
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Raster position and stride phase of the pixel currently offered.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      col    <= 8'd0;
      row    <= 8'd0;
      col_ph <= 2'd0;
      row_ph <= 2'd0;
    end else if (accept) begin
      if (col == last_idx) begin
        col    <= 8'd0;
        col_ph <= 2'd0;
        if (row == last_idx) begin
          row    <= 8'd0;
          row_ph <= 2'd0;
        end else begin
          row    <= row + 8'd1;
          if (row >= km1)
            row_ph <= (row_ph == s_last) ? 2'd0 : row_ph + 2'd1;
          else
            row_ph <= 2'd0;
        end
      end else begin
        col <= col + 8'd1;
        if (col >= km1)
          col_ph <= (col_ph == s_last) ? 2'd0 : col_ph + 2'd1;
        else
          col_ph <= 2'd0;
      end
    end
  end

  // K-1 cascaded line delays per channel; stage j yields the pixel j+1
  // lines above the incoming one.
  for (genvar ch = 0; ch < Tn; ch++) begin : g_ch
    for (genvar j = 0; j < K - 1; j++) begin : g_line
      logic [FW-1:0] line_in;
      if (j == 0) begin : g_first
        assign line_in = in_data[ch*FW +: FW];
      end else begin : g_next
        assign line_in = line_out[ch][j-1];
      end
      line_fifo #(
        .FW    (FW),
        .DEPTH (MAX_FEAT)
      ) u_line (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .en       (accept),
        .last_idx (last_idx),
        .din      (line_in),
        .dout     (line_out[ch][j])
      );
    end
  end

  // New window column (oldest line at row 0), the shifted window, and the
  // k x k masked view anchored at the bottom-right corner.
  always_comb begin
    win_masked = '0;
    for (int ch = 0; ch < Tn; ch++) begin
      col_in[ch][K-1] = in_data[ch*FW +: FW];
      for (int j = 0; j < K - 1; j++)
        col_in[ch][K-2-j] = line_out[ch][j];
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++)
          win_nxt[ch][r][c] = win[ch][r][c+1];
        win_nxt[ch][r][K-1] = col_in[ch][r];
      end
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          if (r + int'(k_cfg) >= K && c + int'(k_cfg) >= K)
            win_masked[idx(ch, r, c, K)*FW +: FW] = win_nxt[ch][r][c];
    end
  end

  // Window shift registers and the output holding register. The output is
  // only reloaded on an emitting beat, which can only be accepted once the
  // previous window has been taken, so out_window is stable while valid.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      for (int ch = 0; ch < Tn; ch++)
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            win[ch][r][c] <= '0;
      out_valid <= 1'b0;
      if (rst)
        out_window <= '0;
    end else begin
      if (accept)
        win <= win_nxt;
      if (emit) begin
        out_window <= win_masked;
        out_valid  <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_gen_array.sv
// ---------------------------------------------------------------------------
// tb_window_gen_array
// Self-checking bench for window_gen_array (Tn=2, FW=8, K=3). Expected
// windows are enumerated directly from the frame contents: every top-left
// (wr, wc) on the stride grid with the kernel fully inside the frame, with
// the k x k patch placed in the bottom-right of the K x K tap grid.
// ---------------------------------------------------------------------------
module tb_window_gen_array;

  localparam int TN = 2;
  localparam int FW = 8;
  localparam int K  = 3;
  localparam int WW = TN * K * K * FW;

  logic              clk;
  logic              rst;
  logic              start;
  logic [2:0]        cfg_kernel_size;
  logic [1:0]        cfg_stride;
  logic [7:0]        cfg_feature_size;
  logic              in_valid;
  logic              in_ready;
  logic [TN*FW-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WW-1:0]     out_window;
  logic              busy;
  logic              done;

  window_gen_array #(
    .Tn            (TN),
    .FEATURE_WIDTH (FW),
    .KERNEL_SIZE   (K)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cfg_kernel_size  (cfg_kernel_size),
    .cfg_stride       (cfg_stride),
    .cfg_feature_size (cfg_feature_size),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_window       (out_window),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [FW-1:0] frame [TN][16][16];
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] got_q[$];
  int cur_w;
  int n_cmp, n_fail;
  int last_acc_cycle, last_hs_cycle, done_cycle, done_count, stall_viol;
  bit timed_out;

  // Frame contents: row*16+col (+0x80 on channel 1) or random bytes.
  task automatic fill_frame(input int w, input bit rnd);
    cur_w = w;
    for (int ch = 0; ch < TN; ch++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++)
          frame[ch][r][c] = rnd ? 8'($urandom) : 8'(r * 16 + c + ch * 128);
  endtask

  // Reference window list for an effective kernel k and stride s.
  task automatic build_expected(input int k, input int s, input int w);
    logic [WW-1:0] v;
    exp_q.delete();
    for (int wr = 0; wr + k <= w; wr += s)
      for (int wc = 0; wc + k <= w; wc += s) begin
        v = '0;
        for (int ch = 0; ch < TN; ch++)
          for (int r = K - k; r < K; r++)
            for (int c = K - k; c < K; c++)
              v[((ch*K + r)*K + c)*FW +: FW] = frame[ch][wr + r - (K-k)][wc + c - (K-k)];
        exp_q.push_back(v);
      end
  endtask

  task automatic start_frame(input logic [2:0] k, input logic [1:0] s, input logic [7:0] fsize);
    @(negedge clk);
    cfg_kernel_size  = k;
    cfg_stride       = s;
    cfg_feature_size = fsize;
    start            = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams 'total' pixels and collects every window handshake. Stops a few
  // cycles after done, at abort_at accepted pixels, or on the cycle budget.
  task automatic run_frame(input int total, input int ready_pct, input int valid_pct,
                           input int abort_at, input int start_at);
    int idx, cyc, after;
    bit done_seen, start_sent;
    idx = 0; cyc = 0; after = 0; done_seen = 0; start_sent = 0;
    got_q.delete();
    last_acc_cycle = -1; last_hs_cycle = -1; done_cycle = -1;
    done_count = 0; stall_viol = 0; timed_out = 0;
    forever begin
      @(negedge clk);
      if (abort_at >= 0 && idx >= abort_at) begin
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      if (idx == start_at && !start_sent) begin
        start = 1'b1;
        cfg_kernel_size  = 3'd1;
        cfg_stride       = 2'd1;
        cfg_feature_size = 8'd7;
        start_sent = 1;
      end else begin
        start = 1'b0;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      if (idx < total && $urandom_range(99) < valid_pct) begin
        in_valid = 1'b1;
        for (int ch = 0; ch < TN; ch++)
          in_data[ch*FW +: FW] = frame[ch][idx / cur_w][idx % cur_w];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        got_q.push_back(out_window);
        last_hs_cycle = cyc;
      end
      if (out_valid && !out_ready && in_ready)
        stall_viol++;
      if (in_valid && in_ready) begin
        idx++;
        last_acc_cycle = cyc;
      end
      if (done) begin
        done_count++;
        if (!done_seen)
          done_cycle = cyc;
        done_seen = 1;
      end
      if (done_seen)
        after++;
      cyc++;
      if (after > 4)
        break;
      if (cyc > 3000) begin
        timed_out = 1;
        break;
      end
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_window !== '0) begin n_fail++; $display("[TB] FAIL reset_out_window got %h want 0", out_window); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", done); end
    rst = 1'b0;
  endtask

  task automatic test_basic_k3s1();
    fill_frame(5, 0);
    build_expected(3, 1, 5);
    start_frame(3'd3, 2'd1, 8'd4);
    run_frame(25, 100, 100, -1, -1);
    n_cmp++; if (timed_out) begin n_fail++; $display("[TB] FAIL s1_timeout got timeout want done"); end
    n_cmp++; if (got_q.size() != 9) begin n_fail++; $display("[TB] FAIL s1_count got %0d want 9", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL s1_win%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > 0) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          n_cmp++;
          if (got_q[0][(r*K + c)*FW +: FW] !== 8'(r*16 + c)) begin
            n_fail++;
            $display("[TB] FAIL s1_first_tap%0d%0d got %h want %h", r, c, got_q[0][(r*K + c)*FW +: FW], 8'(r*16 + c));
          end
        end
    end
    n_cmp++; if (done_count != 1) begin n_fail++; $display("[TB] FAIL s1_done_width got %0d want 1", done_count); end
    n_cmp++; if (done_cycle != last_hs_cycle + 1) begin n_fail++; $display("[TB] FAIL s1_done_time got %0d want %0d", done_cycle, last_hs_cycle + 1); end
  endtask

  task automatic test_stride2();
    fill_frame(7, 0);
    build_expected(3, 2, 7);
    start_frame(3'd3, 2'd2, 8'd6);
    run_frame(49, 100, 100, -1, -1);
    n_cmp++; if (timed_out) begin n_fail++; $display("[TB] FAIL s2_timeout got timeout want done"); end
    n_cmp++; if (got_q.size() != 9) begin n_fail++; $display("[TB] FAIL s2_count got %0d want 9", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL s2_win%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_k1();
    fill_frame(4, 1);
    build_expected(1, 1, 4);
    start_frame(3'd1, 2'd1, 8'd3);
    run_frame(16, 100, 100, -1, -1);
    n_cmp++; if (timed_out) begin n_fail++; $display("[TB] FAIL s3_timeout got timeout want done"); end
    n_cmp++; if (got_q.size() != 16) begin n_fail++; $display("[TB] FAIL s3_count got %0d want 16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL s3_win%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    fill_frame(8, 1);
    build_expected(3, 1, 8);
    start_frame(3'd3, 2'd1, 8'd7);
    run_frame(64, 50, 80, -1, -1);
    n_cmp++; if (timed_out) begin n_fail++; $display("[TB] FAIL s4_timeout got timeout want done"); end
    n_cmp++; if (got_q.size() != 36) begin n_fail++; $display("[TB] FAIL s4_count got %0d want 36", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL s4_win%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (stall_viol != 0) begin n_fail++; $display("[TB] FAIL s4_stall_ready got %0d want 0", stall_viol); end
  endtask

  task automatic test_reset_midframe();
    fill_frame(5, 1);
    start_frame(3'd3, 2'd1, 8'd4);
    run_frame(25, 100, 100, 20, -1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL s5_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL s5_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_window !== '0) begin n_fail++; $display("[TB] FAIL s5_out_window got %h want 0", out_window); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL s5_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL s5_done got %b want 0", done); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL s5_no_done got %b want 0", done); end
    end
    test_basic_k3s1();
  endtask

  task automatic test_small_frame();
    fill_frame(2, 1);
    start_frame(3'd3, 2'd1, 8'd1);
    run_frame(4, 100, 100, -1, 2);
    n_cmp++; if (timed_out) begin n_fail++; $display("[TB] FAIL s6_timeout got timeout want done"); end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("[TB] FAIL s6_count got %0d want 0", got_q.size()); end
    n_cmp++; if (done_count != 1) begin n_fail++; $display("[TB] FAIL s6_done_width got %0d want 1", done_count); end
    n_cmp++;
    if (done_cycle - last_acc_cycle < 1 || done_cycle - last_acc_cycle > 2) begin
      n_fail++;
      $display("[TB] FAIL s6_done_time got %0d want 1..2 after last pixel", done_cycle - last_acc_cycle);
    end
  endtask

  task automatic test_illegal_cfg();
    fill_frame(3, 1);
    build_expected(1, 1, 3);
    start_frame(3'd0, 2'd0, 8'd2);
    run_frame(9, 100, 100, -1, -1);
    n_cmp++; if (timed_out) begin n_fail++; $display("[TB] FAIL clamp_timeout got timeout want done"); end
    n_cmp++; if (got_q.size() != 9) begin n_fail++; $display("[TB] FAIL clamp_count got %0d want 9", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL clamp_win%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    cfg_kernel_size = 3'd0;
    cfg_stride = 2'd0;
    cfg_feature_size = 8'd0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    cur_w = 1;
    test_reset();
    test_basic_k3s1();
    test_stride2();
    test_k1();
    test_backpressure();
    test_reset_midframe();
    test_small_frame();
    test_illegal_cfg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
